// File: rtl/decode_format_dispatch.sv
// decode_format_dispatch
//
// Front-of-decode dispatch stage. One fetched instruction per cycle is
// classified by its primary opcode into a one-hot format code. It is then
// buffered in a small FIFO and presented, with its metadata, to the
// per-format decoders through a registered output stage.
//
// Ports:
//   clock_i                clock, rising edge
//   reset_i                asynchronous, active-low reset
//   enable_i               input instruction valid
//   instruction_i          instruction; the primary opcode is the top 6 bits
//                          (big-endian bits [0:5])
//   instructionAddress_i   instruction address
//   is64Bit_i              64-bit mode
//   instructionPid_i       process ID
//   instructionTid_i       thread ID
//   instructionMajId_i     major ID
//   flush_i                synchronous flush; overrides stall_i
//   stall_i                downstream decoders cannot accept
//   stall_o                buffer full; fetch must hold
//   enable_o               output instruction valid
//   instFormat_o           one-hot format code (0 for illegal opcodes)
//   instructionOpcode_o    primary opcode of the presented instruction
//   instruction_o .. instructionMajId_o   registered copies of the inputs
//   illegal_o              primary opcode has no format
//
// Build option:
//   DISPATCH_ILLEGAL_DROP_EN - when defined, illegal instructions are never
//   buffered. Instead, they are reported by a one-cycle illegal_o pulse
//   with enable_o=0.

module decode_format_dispatch #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int PrimOpcodeSize          = 6,
  parameter int formatCount             = 25,
  parameter int fifoDepth               = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  input  logic                               flush_i,
  input  logic                               stall_i,
  output logic                               stall_o,
  output logic                               enable_o,
  output logic [formatCount-1:0]             instFormat_o,
  output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o,
  output logic                               illegal_o
);

  localparam int PtrW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(fifoDepth);

  typedef struct packed {
    logic [instructionWidth-1:0]        instruction;
    logic [addressWidth-1:0]            address;
    logic                               is64Bit;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] majId;
    logic [formatCount-1:0]             format;
    logic                               illegal;
  } entry_t;

  // Opcode to one-hot format. Bit positions: I=0, B=1, SC=2, D=3, DS=4,
  // DQ=5, X=6, XL=7, M=8, MD=9, A=10, VX=11. Bits 12..24 are reserved.
  function automatic logic [formatCount-1:0] classifyOpcode(
    input logic [PrimOpcodeSize-1:0] op
  );
    logic [formatCount-1:0] f;
    f = '0;
    case (op) inside
      6'd18:                                        f[0]  = 1'b1;
      6'd16:                                        f[1]  = 1'b1;
      6'd17:                                        f[2]  = 1'b1;
      6'd7, 6'd8, [6'd10:6'd15], [6'd24:6'd29],
      [6'd32:6'd55]:                                f[3]  = 1'b1;
      6'd57, 6'd58, 6'd61, 6'd62:                   f[4]  = 1'b1;
      6'd56:                                        f[5]  = 1'b1;
      6'd31, 6'd60:                                 f[6]  = 1'b1;
      6'd19:                                        f[7]  = 1'b1;
      6'd20, 6'd21, 6'd23:                          f[8]  = 1'b1;
      6'd30:                                        f[9]  = 1'b1;
      6'd59, 6'd63:                                 f[10] = 1'b1;
      6'd4:                                         f[11] = 1'b1;
      default:                                      f     = '0;
    endcase
    return f;
  endfunction

  entry_t fifoMem [fifoDepth];
  entry_t inEntry;
  entry_t outQ, outD;
  logic   enableQ, enableD;
  logic [PtrW-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [CntW-1:0] countQ, countD;

  logic inIllegal;
  logic fifoEmpty;
  logic accept;
  logic push;
  logic pop;
  logic bypass;
  logic fifoWrite;
  logic dropReport;

  // Classify the incoming instruction and package it as a FIFO entry.
  always_comb begin
    inEntry             = '0;
    inEntry.instruction = instruction_i;
    inEntry.address     = instructionAddress_i;
    inEntry.is64Bit     = is64Bit_i;
    inEntry.pid         = instructionPid_i;
    inEntry.tid         = instructionTid_i;
    inEntry.majId       = instructionMajId_i;
    inEntry.format      = classifyOpcode(
                            instruction_i[instructionWidth-1 -: PrimOpcodeSize]);
    inEntry.illegal     = (inEntry.format == '0);
  end

  assign inIllegal = inEntry.illegal;
  assign stall_o   = (countQ == CountFull);
  assign fifoEmpty = (countQ == '0);

  // An instruction offered while full is an upstream violation and is ignored.
  assign accept = enable_i & ~stall_o & ~flush_i;

`ifdef DISPATCH_ILLEGAL_DROP_EN
  // Illegal instructions never enter the buffer. They are reported only when
  // the output stage is idle and free to take them. Otherwise, the report
  // would displace a held or queued legal instruction, so it is silently
  // dropped.
  assign push       = accept & ~inIllegal;
  assign dropReport = accept & inIllegal & fifoEmpty & ~stall_i;
`else
  assign push       = accept;
  assign dropReport = 1'b0;
`endif

  assign pop       = ~stall_i & ~fifoEmpty;
  assign bypass    = push & fifoEmpty & ~stall_i;
  assign fifoWrite = push & ~bypass;

  // Pointer and occupancy update. Simultaneous write and pop leave the count
  // unchanged. Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (flush_i) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
    end else begin
      if (fifoWrite) wrPtrD = wrPtrQ + 1'b1;
      if (pop)       rdPtrD = rdPtrQ + 1'b1;
      countD = countQ + CntW'(fifoWrite) - CntW'(pop);
    end
  end

  // Output stage. When the stage is not stalled, the queued head takes
  // priority over a bypassed input; an empty FIFO makes them mutually
  // exclusive anyway. When stalled, everything holds, except that a flush
  // still clears the stage.
  always_comb begin
    outD    = outQ;
    enableD = enableQ;
    if (flush_i) begin
      outD    = '0;
      enableD = 1'b0;
    end else if (!stall_i) begin
      if (pop) begin
        outD    = fifoMem[rdPtrQ];
        enableD = 1'b1;
      end else if (bypass) begin
        outD    = inEntry;
        enableD = 1'b1;
      end else if (dropReport) begin
        outD    = inEntry;
        enableD = 1'b0;
      end else begin
        enableD      = 1'b0;
        outD.illegal = 1'b0;
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock_i) begin
    if (fifoWrite) fifoMem[wrPtrQ] <= inEntry;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wrPtrQ  <= '0;
      rdPtrQ  <= '0;
      countQ  <= '0;
      outQ    <= '0;
      enableQ <= 1'b0;
    end else begin
      wrPtrQ  <= wrPtrD;
      rdPtrQ  <= rdPtrD;
      countQ  <= countD;
      outQ    <= outD;
      enableQ <= enableD;
    end
  end

  assign enable_o             = enableQ;
  assign instFormat_o         = outQ.format;
  assign illegal_o            = outQ.illegal;
  assign instruction_o        = outQ.instruction;
  assign instructionOpcode_o  = outQ.instruction[instructionWidth-1 -: PrimOpcodeSize];
  assign instructionAddress_o = outQ.address;
  assign is64Bit_o            = outQ.is64Bit;
  assign instructionPid_o     = outQ.pid;
  assign instructionTid_o     = outQ.tid;
  assign instructionMajId_o   = outQ.majId;

endmodule

// File: tb/tb_decode_format_dispatch.sv
// Directed testbench for decode_format_dispatch. It covers reset values,
// bypass latency, the full opcode map, backpressure and ordering, flush,
// and asynchronous reset in mid-stream. The expected illegal-drop behaviour
// follows DISPATCH_ILLEGAL_DROP_EN.

module tb_decode_format_dispatch;

  logic        clock = 1'b0;
  logic        resetN;
  logic        enableIn;
  logic [31:0] instructionIn;
  logic [63:0] addressIn;
  logic        is64In;
  logic [19:0] pidIn;
  logic [15:0] tidIn;
  logic [63:0] majIdIn;
  logic        flushIn;
  logic        stallIn;

  logic        stallOut;
  logic        enableOut;
  logic [24:0] formatOut;
  logic [5:0]  opcodeOut;
  logic [31:0] instructionOut;
  logic [63:0] addressOut;
  logic        is64Out;
  logic [19:0] pidOut;
  logic [15:0] tidOut;
  logic [63:0] majIdOut;
  logic        illegalOut;

  int vectorCount = 0;
  int missCount   = 0;

  decode_format_dispatch dut (
    .clock_i              (clock),
    .reset_i              (resetN),
    .enable_i             (enableIn),
    .instruction_i        (instructionIn),
    .instructionAddress_i (addressIn),
    .is64Bit_i            (is64In),
    .instructionPid_i     (pidIn),
    .instructionTid_i     (tidIn),
    .instructionMajId_i   (majIdIn),
    .flush_i              (flushIn),
    .stall_i              (stallIn),
    .stall_o              (stallOut),
    .enable_o             (enableOut),
    .instFormat_o         (formatOut),
    .instructionOpcode_o  (opcodeOut),
    .instruction_o        (instructionOut),
    .instructionAddress_o (addressOut),
    .is64Bit_o            (is64Out),
    .instructionPid_o     (pidOut),
    .instructionTid_o     (tidOut),
    .instructionMajId_o   (majIdOut),
    .illegal_o            (illegalOut)
  );

  // Free-running clock with 10 ns period. Rising edges occur at 5, 15, 25 ns, and so on.
  always #5 clock = ~clock;

  // Watchdog: the run ends even if the sequence below stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference opcode map, written straight from the format table.
  function automatic logic [24:0] refFormat(input int op);
    if (op == 18) return 25'd1;
    if (op == 16) return 25'd2;
    if (op == 17) return 25'd4;
    if (op == 7 || op == 8 || (op >= 10 && op <= 15) ||
        (op >= 24 && op <= 29) || (op >= 32 && op <= 55)) return 25'd8;
    if (op == 57 || op == 58 || op == 61 || op == 62) return 25'd16;
    if (op == 56) return 25'd32;
    if (op == 31 || op == 60) return 25'd64;
    if (op == 19) return 25'd128;
    if (op == 20 || op == 21 || op == 23) return 25'd256;
    if (op == 30) return 25'd512;
    if (op == 59 || op == 63) return 25'd1024;
    if (op == 4) return 25'd2048;
    return 25'd0;
  endfunction

  // Single comparison point: every check is counted here, and each mismatch is reported.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs. The address is derived from the major ID so that each entry is distinguishable.
  task automatic applyStimulus(input logic en, input logic [5:0] op,
                               input logic [63:0] majId, input logic stall,
                               input logic flush);
    logic [25:0] lowBits;
    lowBits       = 26'h0001234;
    enableIn      = en;
    instructionIn = {op, lowBits};
    addressIn     = majId << 2;
    is64In        = 1'b1;
    pidIn         = 20'hABCDE;
    tidIn         = 16'h5A5A;
    majIdIn       = majId;
    stallIn       = stall;
    flushIn       = flush;
  endtask

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;
    int expPulses;
    logic [24:0] ef;

    resetN = 1'b0;
    applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
    #12;
    $display("[TB] reset values");
    checkOutput("rstEnable",  enableOut,      1'b0);
    checkOutput("rstStall",   stallOut,       1'b0);
    checkOutput("rstFormat",  formatOut,      25'd0);
    checkOutput("rstIllegal", illegalOut,     1'b0);
    checkOutput("rstInstr",   instructionOut, 32'd0);
    checkOutput("rstMajId",   majIdOut,       64'd0);
    #1 resetN = 1'b1;
    tick();

    // Single instruction into an empty FIFO: one-cycle bypass.
    $display("[TB] single bypass");
    applyStimulus(1'b1, 6'd16, 64'd5, 1'b0, 1'b0);
    tick();
    checkOutput("byEnable", enableOut, 1'b1);
    checkOutput("byMajId",  majIdOut,  64'd5);
    checkOutput("byOpcode", opcodeOut, 6'd16);
    checkOutput("byFormat", formatOut, 25'd2);
    checkOutput("byAddr",   addressOut, 64'd20);
    checkOutput("byPid",    pidOut,    20'hABCDE);
    applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("byIdle", enableOut, 1'b0);

    // Opcode sweep: one instruction every two cycles.
    $display("[TB] opcode sweep");
    pulses    = 0;
    expPulses = 0;
    for (int op = 0; op < 64; op++) begin
      ef = refFormat(op);
      applyStimulus(1'b1, 6'(op), 64'(op + 100), 1'b0, 1'b0);
      tick();
      if (enableOut) pulses++;
`ifdef DISPATCH_ILLEGAL_DROP_EN
      if (ef == 25'd0) begin
        checkOutput("swDropEnable",  enableOut,      1'b0);
        checkOutput("swDropIllegal", illegalOut,     1'b1);
        checkOutput("swDropInstr",   instructionOut, {6'(op), 26'h0001234});
        checkOutput("swDropMajId",   majIdOut,       64'(op + 100));
      end else begin
        expPulses++;
        checkOutput("swEnable",  enableOut,  1'b1);
        checkOutput("swFormat",  formatOut,  ef);
        checkOutput("swIllegal", illegalOut, 1'b0);
        checkOutput("swMajId",   majIdOut,   64'(op + 100));
      end
`else
      expPulses++;
      checkOutput("swEnable",  enableOut,  1'b1);
      checkOutput("swFormat",  formatOut,  ef);
      checkOutput("swIllegal", illegalOut, (ef == 25'd0));
      checkOutput("swMajId",   majIdOut,   64'(op + 100));
`endif
      if (op == 16) checkOutput("sw16Format", formatOut, 25'd2);
      if (op == 18) checkOutput("sw18Format", formatOut, 25'd1);
      if (op == 31) checkOutput("sw31Format", formatOut, 25'd64);
      if (op == 0)  checkOutput("sw0Illegal", illegalOut, 1'b1);
      applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
      tick();
      if (enableOut) pulses++;
`ifdef DISPATCH_ILLEGAL_DROP_EN
      checkOutput("swPulseEnd", illegalOut, 1'b0);
`endif
    end
    checkOutput("swPulses", 64'(pulses), 64'(expPulses));

    // Backpressure: fill to full while stalled, then drain in order.
    $display("[TB] stall and fill");
    applyStimulus(1'b0, 6'd0, 64'd0, 1'b1, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 6'd16, 64'(i), 1'b1, 1'b0);
      tick();
      checkOutput("fillStall",  stallOut,  (i == 4));
      checkOutput("fillEnable", enableOut, 1'b0);
    end
    applyStimulus(1'b1, 6'd16, 64'd99, 1'b1, 1'b0);
    tick();
    checkOutput("fullStall",  stallOut,  1'b1);
    checkOutput("fullEnable", enableOut, 1'b0);
    applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("drainEnable", enableOut, 1'b1);
      checkOutput("drainMajId",  majIdOut,  64'(i));
      if (i == 1) checkOutput("drainStall", stallOut, 1'b0);
    end
    tick();
    checkOutput("drainDone", enableOut, 1'b0);

    // Flush with two entries queued; the flush overrides the stall, and it drops the same-cycle push.
    $display("[TB] flush");
    applyStimulus(1'b1, 6'd16, 64'd21, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 6'd16, 64'd22, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 6'd16, 64'd23, 1'b1, 1'b1);
    tick();
    checkOutput("flEnable", enableOut, 1'b0);
    checkOutput("flStall",  stallOut,  1'b0);
    checkOutput("flFormat", formatOut, 25'd0);
    applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("flQuiet", enableOut, 1'b0);
    end

    // Asynchronous reset while full and presenting a valid instruction.
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 6'd16, 64'd10, 1'b0, 1'b0);
    tick();
    checkOutput("msEnable", enableOut, 1'b1);
    checkOutput("msMajId",  majIdOut,  64'd10);
    for (int i = 11; i <= 14; i++) begin
      applyStimulus(1'b1, 6'd16, 64'(i), 1'b1, 1'b0);
      tick();
    end
    checkOutput("msFull",   stallOut,  1'b1);
    checkOutput("msHold",   enableOut, 1'b1);
    applyStimulus(1'b0, 6'd0, 64'd0, 1'b1, 1'b0);
    #2 resetN = 1'b0;
    #1;
    checkOutput("arEnable", enableOut, 1'b0);
    checkOutput("arStall",  stallOut,  1'b0);
    checkOutput("arMajId",  majIdOut,  64'd0);
    #2 resetN = 1'b1;
    applyStimulus(1'b1, 6'd16, 64'd77, 1'b0, 1'b0);
    tick();
    checkOutput("postEnable", enableOut, 1'b1);
    checkOutput("postMajId",  majIdOut,  64'd77);
    applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("postIdle", enableOut, 1'b0);

`ifdef DISPATCH_ILLEGAL_DROP_EN
    // An illegal opcode is reported once and never occupies the buffer.
    $display("[TB] illegal drop");
    applyStimulus(1'b1, 6'd1, 64'd55, 1'b0, 1'b0);
    tick();
    checkOutput("dropIllegal", illegalOut, 1'b1);
    checkOutput("dropEnable",  enableOut,  1'b0);
    checkOutput("dropMajId",   majIdOut,   64'd55);
    applyStimulus(1'b1, 6'd16, 64'd56, 1'b0, 1'b0);
    tick();
    checkOutput("dropNextEnable", enableOut, 1'b1);
    checkOutput("dropNextMajId",  majIdOut,  64'd56);
    checkOutput("dropNextIllegal", illegalOut, 1'b0);
    applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("dropEmpty", enableOut, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
